// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: receive-side model of the 4-wire LCD SPI panel controller.
// Deserialises i_mosi (MSB first) while i_cs is low, tags each byte with i_dc,
// decodes CASET / PASET / RAMWR and emits addressed RGB565 pixels.
// Ports:
//   i_clk, i_rst_n        clock (also SPI bit clock), async active-low reset
//   i_cs, i_dc, i_mosi    SPI chip select (low active), data/command, serial data
//   o_byte, o_byte_dc     last complete byte and its D/C tag
//   o_byte_valid          1-cycle pulse when o_byte/o_byte_dc update
//   o_pix_valid           1-cycle pulse, o_pix_data/x/y hold a written pixel
//   o_pix_data/x/y        RGB565 pixel and its column/row
//   o_frame_done          pulses with the last pixel of the window
//   o_err                 pulses on rejected window or dropped partial byte
module spi_lcd_rx #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cs,
  input  logic        i_dc,
  input  logic        i_mosi,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_byte_valid,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_data,
  output logic [15:0] o_pix_x,
  output logic [15:0] o_pix_y,
  output logic        o_frame_done,
  output logic        o_err
);
  typedef enum logic [1:0] {S_CMD, S_CASET, S_PASET, S_RAMWR} state_t;

  localparam logic [15:0] COL_LIM = 16'(WIDTH);
  localparam logic [15:0] ROW_LIM = 16'(HEIGHT);

  logic [6:0]  sh_q;
  logic [2:0]  cnt_q;
  logic [7:0]  byte_q;
  logic        byte_dc_q, byte_valid_q;

  state_t      state_q, state_d;
  logic [1:0]  arg_q, arg_d;
  logic [23:0] shadow_q, shadow_d;
  logic [15:0] col_s_q, col_s_d, col_e_q, col_e_d;
  logic [15:0] row_s_q, row_s_d, row_e_q, row_e_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [7:0]  hi_q, hi_d;
  logic        phase_q, phase_d;
  logic        pix_valid_q, pix_valid_d, fdone_q, fdone_d, err_q, err_d;
  logic [15:0] pix_data_q, pix_data_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  // The decoder acts on the byte as it completes, so pixel outputs register
  // on the same edge as the byte and pulse together with o_byte_valid.
  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] arg_start, arg_end;
  assign byte_done = !i_cs && (cnt_q == 3'd7);
  assign rx_byte   = {sh_q, i_mosi};
  assign arg_start = shadow_q[23:8];
  assign arg_end   = {shadow_q[7:0], rx_byte};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q         <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= byte_done;
      if (i_cs) begin
        cnt_q <= '0;
      end else begin
        sh_q  <= {sh_q[5:0], i_mosi};
        cnt_q <= cnt_q + 3'd1;
      end
      if (byte_done) begin
        byte_q    <= rx_byte;
        byte_dc_q <= i_dc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    shadow_d    = shadow_q;
    col_s_d     = col_s_q;
    col_e_d     = col_e_q;
    row_s_d     = row_s_q;
    row_e_d     = row_e_q;
    x_d         = x_q;
    y_d         = y_q;
    hi_d        = hi_q;
    phase_d     = phase_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    fdone_d     = 1'b0;
    // CS rising with a partial byte in flight drops that byte.
    err_d       = i_cs && (cnt_q != 3'd0);
    if (byte_done) begin
      if (!i_dc) begin
        arg_d = 2'd0;
        case (rx_byte)
          8'h2A:   state_d = S_CASET;
          8'h2B:   state_d = S_PASET;
          8'h2C: begin
            state_d = S_RAMWR;
            x_d     = col_s_q;
            y_d     = row_s_q;
            phase_d = 1'b0;
          end
          default: state_d = S_CMD;
        endcase
      end else begin
        case (state_q)
          S_CASET, S_PASET: begin
            arg_d = arg_q + 2'd1;
            case (arg_q)
              2'd0: shadow_d[23:16] = rx_byte;
              2'd1: shadow_d[15:8]  = rx_byte;
              2'd2: shadow_d[7:0]   = rx_byte;
              default: begin
                state_d = S_CMD;
                if (state_q == S_CASET) begin
                  if (arg_start <= arg_end && arg_end < COL_LIM) begin
                    col_s_d = arg_start;
                    col_e_d = arg_end;
                  end else err_d = 1'b1;
                end else begin
                  if (arg_start <= arg_end && arg_end < ROW_LIM) begin
                    row_s_d = arg_start;
                    row_e_d = arg_end;
                  end else err_d = 1'b1;
                end
              end
            endcase
          end
          S_RAMWR: begin
            if (!phase_q) begin
              hi_d    = rx_byte;
              phase_d = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, rx_byte};
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              if (x_q == col_e_q) begin
                x_d = col_s_q;
                if (y_q == row_e_q) begin
                  y_d     = row_s_q;
                  fdone_d = 1'b1;
                end else y_d = y_q + 16'd1;
              end else x_d = x_q + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_CMD;
      arg_q       <= '0;
      shadow_q    <= '0;
      col_s_q     <= '0;
      col_e_q     <= COL_LIM - 16'd1;
      row_s_q     <= '0;
      row_e_q     <= ROW_LIM - 16'd1;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      phase_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      fdone_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      shadow_q    <= shadow_d;
      col_s_q     <= col_s_d;
      col_e_q     <= col_e_d;
      row_s_q     <= row_s_d;
      row_e_q     <= row_e_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      fdone_q     <= fdone_d;
      err_q       <= err_d;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_dc    = byte_dc_q;
  assign o_byte_valid = byte_valid_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_data   = pix_data_q;
  assign o_pix_x      = pix_x_q;
  assign o_pix_y      = pix_y_q;
  assign o_frame_done = fdone_q;
  assign o_err        = err_q;
endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx: self-checking bench for spi_lcd_rx (WIDTH=24, HEIGHT=32).
// Expected bytes/pixels go into queues as stimulus is driven; a negedge
// monitor pops and compares them as the DUT produces output.
module tb_spi_lcd_rx;
  localparam int W = 24;
  localparam int H = 32;

  logic        clk = 1'b0;
  logic        rst_n, cs, dc, mosi;
  logic [7:0]  o_byte;
  logic        o_byte_dc, o_byte_valid, o_pix_valid, o_frame_done, o_err;
  logic [15:0] o_pix_data, o_pix_x, o_pix_y;

  spi_lcd_rx #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_dc(dc), .i_mosi(mosi),
    .o_byte(o_byte), .o_byte_dc(o_byte_dc), .o_byte_valid(o_byte_valid),
    .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data), .o_pix_x(o_pix_x),
    .o_pix_y(o_pix_y), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #10 clk = ~clk;

  typedef struct { logic [7:0] b; logic dc; } byte_t;
  typedef struct { logic [15:0] d, x, y; logic fd; } pix_t;
  typedef struct { logic [7:0] cmd; logic [15:0] s, e; logic exp_err; } win_t;

  byte_t bq[$];
  pix_t  pq[$];
  byte_t eb;
  pix_t  ep;
  int checks = 0, errors = 0, err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_byte_valid) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %0h expected none", o_byte);
        end else begin
          eb = bq.pop_front();
          if (o_byte !== eb.b || o_byte_dc !== eb.dc) begin
            errors++;
            $display("FAIL byte got %0h/%0b expected %0h/%0b", o_byte, o_byte_dc, eb.b, eb.dc);
          end
        end
      end
      if (o_pix_valid) begin
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel got (%0d,%0d)", o_pix_x, o_pix_y);
        end else begin
          ep = pq.pop_front();
          if (o_pix_data !== ep.d || o_pix_x !== ep.x || o_pix_y !== ep.y || o_frame_done !== ep.fd) begin
            errors++;
            $display("FAIL pixel got %0h (%0d,%0d) fd=%0b expected %0h (%0d,%0d) fd=%0b",
                     o_pix_data, o_pix_x, o_pix_y, o_frame_done, ep.d, ep.x, ep.y, ep.fd);
          end
        end
      end
      if (o_frame_done && !o_pix_valid) begin
        checks++;
        errors++;
        $display("FAIL frame_done_alone got 1 expected 0");
      end
      if (o_err) err_seen++;
    end
  end

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      @(negedge clk);
      cs = 1'b0; dc = d; mosi = b[i];
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    byte_t e;
    e.b = b; e.dc = d;
    bq.push_back(e);
    send_bits(b, d, 8);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b1; mosi = 1'b0;
    end
  endtask

  task automatic send_pix(input logic [15:0] d);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic push_pix(input logic [15:0] d, input logic [15:0] x, input logic [15:0] y, input logic fd);
    pix_t p;
    p.d = d; p.x = x; p.y = y; p.fd = fd;
    pq.push_back(p);
  endtask

  task automatic win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_byte(cmd, 1'b0);
    send_byte(s[15:8], 1'b1);
    send_byte(s[7:0], 1'b1);
    send_byte(e[15:8], 1'b1);
    send_byte(e[7:0], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bq.delete();
    pq.delete();
  endtask

  win_t tbl[5];
  logic [15:0] mcs, mce, mrs, mre, px, py;
  int e0;

  initial begin
    tbl[0] = '{8'h2A, 16'd5,  16'd3,  1'b1};  // start > end
    tbl[1] = '{8'h2A, 16'd0,  16'd24, 1'b1};  // end == WIDTH
    tbl[2] = '{8'h2A, 16'd0,  16'd23, 1'b0};  // end == WIDTH-1, legal
    tbl[3] = '{8'h2B, 16'd0,  16'd32, 1'b1};  // end == HEIGHT
    tbl[4] = '{8'h2B, 16'd30, 16'd31, 1'b0};

    rst_n = 1'b0; cs = 1'b1; dc = 1'b0; mosi = 1'b0;
    #25;
    chk("reset_byte_valid", o_byte_valid, 0);
    chk("reset_pix_valid", o_pix_valid, 0);
    chk("reset_err", o_err, 0);
    chk("reset_pix_xy", {o_pix_x, o_pix_y}, 0);
    do_reset();

    // 1: single command byte, latency one cycle after the LSB edge
    send_byte(8'hA5, 1'b0);
    idle(1);
    chk("t1_valid_lat", o_byte_valid, 1);
    chk("t1_byte", {o_byte_dc, o_byte}, {1'b0, 8'hA5});
    idle(1);
    chk("t1_valid_pulse", o_byte_valid, 0);

    // 2: 4x2 window fill
    e0 = err_seen;
    win(8'h2A, 16'd2, 16'd5);
    win(8'h2B, 16'd1, 16'd2);
    send_byte(8'h2C, 1'b0);
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 5; x++) begin
        push_pix(16'hF800, 16'(x), 16'(y), (x == 5 && y == 2));
        send_pix(16'hF800);
      end
    idle(3);
    chk("t2_no_err", err_seen - e0, 0);
    chk("t2_pix_drained", pq.size(), 0);

    // 3: full reset-window frame, then wrap to origin
    do_reset();
    send_byte(8'h2C, 1'b0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        push_pix(16'h0000, 16'(x), 16'(y), (x == W - 1 && y == H - 1));
        send_pix(16'h0000);
      end
    push_pix(16'h0000, 16'd0, 16'd0, 1'b0);
    send_pix(16'h0000);
    idle(3);
    chk("t3_pix_drained", pq.size(), 0);

    // 4: window commands from the table, then a RAMWR over the result
    mcs = 0; mce = 16'(W - 1); mrs = 0; mre = 16'(H - 1);
    for (int i = 0; i < 5; i++) begin
      e0 = err_seen;
      win(tbl[i].cmd, tbl[i].s, tbl[i].e);
      idle(2);
      chk($sformatf("t4_win%0d_err", i), err_seen - e0, {31'd0, tbl[i].exp_err});
      if (!tbl[i].exp_err) begin
        if (tbl[i].cmd == 8'h2A) begin mcs = tbl[i].s; mce = tbl[i].e; end
        else begin mrs = tbl[i].s; mre = tbl[i].e; end
      end
    end
    send_byte(8'h2C, 1'b0);
    px = mcs; py = mrs;
    for (int k = 0; k < 25; k++) begin
      push_pix(16'h1000 + 16'(k), px, py, (px == mce && py == mre));
      send_pix(16'h1000 + 16'(k));
      if (px == mce) begin
        px = mcs;
        py = (py == mre) ? mrs : py + 16'd1;
      end else px = px + 16'd1;
    end
    idle(3);
    chk("t4_pix_drained", pq.size(), 0);

    // 5: partial byte dropped on CS rise, next byte decodes
    e0 = err_seen;
    send_bits(8'hC3, 1'b0, 5);
    idle(3);
    chk("t5_partial_err", err_seen - e0, 1);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h77, 1'b1);  // data in S_CMD: byte only, no pixel
    idle(3);
    chk("t5_byte_drained", bq.size(), 0);

    // 6: async reset mid-pixel
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1);
    send_bits(8'h34, 1'b1, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_byte", {o_byte_dc, o_byte}, 0);
    chk("t6_rst_pix", {o_pix_data, o_pix_x, o_pix_y}, 0);
    chk("t6_rst_pulses", {o_byte_valid, o_pix_valid, o_frame_done, o_err}, 0);
    cs = 1'b1;
    bq.delete();
    pq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h2C, 1'b0);
    push_pix(16'hABCD, 16'd0, 16'd0, 1'b0);
    send_pix(16'hABCD);
    idle(3);

    chk("end_bq_empty", bq.size(), 0);
    chk("end_pq_empty", pq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
